sprite_draw_engine: RTL
=======================

// Module: sprite_draw_engine
// PURPOSE
//  Sweeps a rectangular pixel region (one 40x40 sprite or the full 160x120 screen) in raster order.
//  For each pixel it issues a sprite/screen ROM address and pipelines the returned 3-bit colour to the VGA adapter as x/y/colour/plot.
//  Sits downstream of the x/y origin registers and colour-select mux; consumes their origin and colour and feeds the VGA adapter.
//  Single draw request per sweep; the game FSM waits on done.
// PARAMETERS
//  SPRITE_W   40   sprite width in pixels
//  SPRITE_H   40   sprite height in pixels
//  SCREEN_W   160  screen width; also row pitch of full-screen ROMs
//  SCREEN_H   120  screen height
//  ROM_LAT    1    ROM read latency in cycles, legal 1..3
// PORTS
//  clk         in   1   system clock; all logic rising-edge
//  reset       in   1   synchronous, active-high reset
//  start       in   1   draw request; sampled only in IDLE
//  fullScreen  in   1   1: sweep SCREEN_WxSCREEN_H from (0,0); 0: sweep SPRITE_WxSPRITE_H from origin
//  xOrigin     in   8   sprite left x; latched at start
//  yOrigin     in   7   sprite top y; latched at start
//  black       in   1   force colour 3'b000 for the whole sweep (erase); latched at start
//  romAddr     out  15  row*width+col of the current pixel within the source image
//  romData     in   3   colour from selected ROM, valid ROM_LAT cycles after romAddr
//  x           out  8   plot x coordinate
//  y           out  7   plot y coordinate
//  colour      out  3   plot colour
//  plot        out  1   write strobe to VGA adapter, one cycle per pixel
//  busy        out  1   sweep in progress
//  done        out  1   one-cycle pulse at sweep completion
// BEHAVIOUR
//  - Reset: FSM=IDLE; romAddr, x, y, colour = 0; plot, busy, done = 0; delay line valid bits cleared.
//  - Reset mid-sweep: abort; plot=0 from the next edge; no done pulse.
//  - FSM IDLE -> SWEEP on start. SWEEP -> DRAIN after last address issued. DRAIN -> IDLE once ROM_LAT cycles elapsed; done pulses on that edge.
//  - In the start edge k: latch origin, mode and black; clear col/row/romAddr to 0.
//  - Pixel i (raster order, col fastest) is addressed in cycle k+1+i and plotted in cycle k+1+i+ROM_LAT.
//  - Let N = W*H (1600 sprite, 19200 screen). busy=1 in cycles k+1 .. k+N+ROM_LAT.
//  - done=1 only in cycle k+N+ROM_LAT+1, together with busy=0.
//  - Address: romAddr increments by 1 per pixel; no multiplier. At col==W-1: col wraps to 0, row increments.
//  - Last pixel: col==W-1 && row==H-1; romAddr == N-1.
//  - Coordinates: x = xOrigin+col, y = yOrigin+row (0 origin in full-screen), delayed ROM_LAT cycles with the pixel.
//  - Clip: a pixel with x>=SCREEN_W or y>=SCREEN_H (including 8/7-bit carry-out) gives plot=0; address still advances.
//  - colour = black ? 3'b000 : romData, registered alongside plot; x/y/colour hold last values when plot=0.
//  - start while busy or in DRAIN: ignored, no queueing. start in the same cycle done is high: accepted (FSM already IDLE).
//  - Origin, black and fullScreen changes after start have no effect until the next start.
// CONFIGURATION
//  SPRITE_TRANSPARENT_EN defined: pixels with romData==3'b111 (white key) and black==0 give plot=0.
//    Address/timing unchanged; busy/done cycle counts identical.
//  SPRITE_TRANSPARENT_EN undefined: every in-bounds pixel plots, including 3'b111.
//  fullScreen sweeps never apply the transparency key, regardless of the macro.
// STRUCTURE
//  Package sprite_draw_pkg: SCREEN_W/H, SPRITE_W/H, COLOUR_W=3, X_W=8, Y_W=7, ADDR_W=15, TRANSPARENT_KEY=3'b111.
//  Package sprite_draw_pkg: state encoding IDLE/SWEEP/DRAIN.
//  Sub-module pixel_delay_line: ROM_LAT-deep shift register of {valid, clip, x, y}; cleared by reset.
//  Top contains FSM, col/row/address counters, clip compare, output register.
// TESTING
//  1 Sprite, origin (90,30), ROM_LAT=1, start@k -> 1600 plots; first (90,30) @k+2; last (129,69) @k+1601.
//    romAddr 0..1599; done @k+1602 only.
//  2 fullScreen=1 -> 19200 plots covering (0,0)..(159,119) exactly once; romAddr row pitch 160; done @k+19202.
//  3 Origin (140,100) -> only col<20, row<20 plot (400 strobes); romAddr still reaches 1599; done timing as test 1.
//  4 black=1, romData random -> every plot has colour 000; start pulsed mid-sweep -> ignored, plot count 1600.
//  5 reset asserted at pixel 500 -> plot=0 next cycle, no done; new start after -> full clean 1600-pixel sweep.
//  6 SPRITE_TRANSPARENT_EN, romData=111 on even addresses -> 800 plots, done timing unchanged.
//    Repeat without the macro -> 1600 plots.

Source files
------------

// File: rtl/sprite_draw_pkg.sv
// ============================================================================
//  Module   : sprite_draw_pkg
//  Purpose  : Shared geometry, widths, state encoding and pixel record for
//             the sprite draw engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;

  localparam logic [COLOUR_W-1:0] TRANSPARENT_KEY = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Per-pixel side information that travels alongside the ROM read.
  typedef struct packed {
    logic           clip;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_t;

endpackage

`default_nettype wire

// File: rtl/pixel_delay_line.sv
// ============================================================================
//  Module   : pixel_delay_line
//  Purpose  : DEPTH-stage shift register carrying {valid, clip, x, y} so the
//             plot coordinates line up with the ROM data returned DEPTH
//             cycles after the address was issued.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_delay_line
  import sprite_draw_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  pix_t pix_i,
  output logic valid_o,
  output pix_t pix_o
);

  logic [DEPTH-1:0] valid_q;
  pix_t             pix_q [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      // Stage 0 captures the new pixel; later stages shift the previous one.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q[i] <= 1'b0;
          pix_q[i]   <= '0;
        end else if (i == 0) begin
          valid_q[i] <= valid_i;
          pix_q[i]   <= pix_i;
        end else begin
          valid_q[i] <= valid_q[(i == 0) ? 0 : i-1];
          pix_q[i]   <= pix_q[(i == 0) ? 0 : i-1];
        end
      end
    end
  endgenerate

  assign valid_o = valid_q[DEPTH-1];
  assign pix_o   = pix_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sprite_draw_engine.sv
// ============================================================================
//  Module   : sprite_draw_engine
//  Purpose  : Raster-order sweep of a 40x40 sprite or the full 160x120
//             screen; issues ROM addresses and forwards the returned colour
//             to the VGA adapter as x/y/colour/plot.
//  Options  : SPRITE_TRANSPARENT_EN - white (3'b111) sprite pixels are not
//             plotted unless erasing in black; full-screen sweeps ignore it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_draw_engine
  import sprite_draw_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                fullScreen,
  input  logic [X_W-1:0]      xOrigin,
  input  logic [Y_W-1:0]      yOrigin,
  input  logic                black,
  output logic [ADDR_W-1:0]   romAddr,
  input  logic [COLOUR_W-1:0] romData,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  state_t              state_q, state_d;
  logic [X_W-1:0]      col_q, col_d;
  logic [Y_W-1:0]      row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lat_q, lat_d;
  logic                full_q, full_d;
  logic                black_q, black_d;
  logic [X_W-1:0]      xorg_q, xorg_d;
  logic [Y_W-1:0]      yorg_q, yorg_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      x_hold_q;
  logic [Y_W-1:0]      y_hold_q;
  logic [COLOUR_W-1:0] colour_hold_q;

  logic [X_W-1:0]      w_last_col;
  logic [Y_W-1:0]      w_last_row;
  logic                w_col_end;
  logic                w_last_pix;
  logic [X_W:0]        w_x_sum;
  logic [Y_W:0]        w_y_sum;
  pix_t                w_pix;
  logic                w_dl_valid;
  pix_t                w_dl_pix;
  logic                w_transparent;

  // Sweep extent follows the mode latched at start.
  assign w_last_col = full_q ? X_W'(SCREEN_W - 1) : X_W'(SPRITE_W - 1);
  assign w_last_row = full_q ? Y_W'(SCREEN_H - 1) : Y_W'(SPRITE_H - 1);
  assign w_col_end  = (col_q == w_last_col);
  assign w_last_pix = w_col_end && (row_q == w_last_row);

  // One extra bit on each sum so an origin near 255/127 wrapping past the
  // counter width is still recognised as off-screen.
  assign w_x_sum   = {1'b0, xorg_q} + {1'b0, col_q};
  assign w_y_sum   = {1'b0, yorg_q} + {1'b0, row_q};
  assign w_pix.clip = (w_x_sum >= (X_W+1)'(SCREEN_W)) || (w_y_sum >= (Y_W+1)'(SCREEN_H));
  assign w_pix.x    = w_x_sum[X_W-1:0];
  assign w_pix.y    = w_y_sum[Y_W-1:0];

  pixel_delay_line #(
    .DEPTH (ROM_LAT)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .valid_i (state_q == SWEEP),
    .pix_i   (w_pix),
    .valid_o (w_dl_valid),
    .pix_o   (w_dl_pix)
  );

`ifdef SPRITE_TRANSPARENT_EN
  assign w_transparent = !black_q && !full_q && (romData == TRANSPARENT_KEY);
`else
  assign w_transparent = 1'b0;
`endif

  // State, counters and latched request parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      full_q  <= 1'b0;
      black_q <= 1'b0;
      xorg_q  <= '0;
      yorg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      full_q  <= full_d;
      black_q <= black_d;
      xorg_q  <= xorg_d;
      yorg_q  <= yorg_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept a request in IDLE, step the raster, then wait out
  // the ROM latency so the last pixel is plotted before done.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    full_d  = full_q;
    black_d = black_q;
    xorg_d  = xorg_q;
    yorg_d  = yorg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          full_d  = fullScreen;
          black_d = black;
          xorg_d  = fullScreen ? '0 : xOrigin;
          yorg_d  = fullScreen ? '0 : yOrigin;
        end
      end
      SWEEP: begin
        if (w_last_pix) begin
          state_d = DRAIN;
          lat_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (w_col_end) begin
            col_d = '0;
            row_d = row_q + Y_W'(1);
          end else begin
            col_d = col_q + X_W'(1);
          end
        end
      end
      DRAIN: begin
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Plot strobe qualifies the delayed pixel with the colour arriving now;
  // coordinates and colour hold their last plotted values otherwise.
  always_comb begin
    plot   = w_dl_valid && !w_dl_pix.clip && !w_transparent;
    x      = x_hold_q;
    y      = y_hold_q;
    colour = colour_hold_q;
    if (plot) begin
      x      = w_dl_pix.x;
      y      = w_dl_pix.y;
      colour = black_q ? '0 : romData;
    end
  end

  // Remember the last plotted pixel for the hold behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_hold_q      <= '0;
      y_hold_q      <= '0;
      colour_hold_q <= '0;
    end else begin
      x_hold_q      <= x;
      y_hold_q      <= y;
      colour_hold_q <= colour;
    end
  end

  assign romAddr = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

`default_nettype wire
